addsub_arbiter: RTL and testbench

- Time-shares one adder_subtractor_with_overflow instance between two requesters using valid/ready handshakes.
- Performs round-robin arbitration, registers the operands, runs one operation, and returns a tagged result.
- Keeps a sticky signed-overflow flag for each requester.
- Sits between two client blocks and the single shared adder/subtractor datapath.

---
 rtl/addsub_arbiter_pkg.sv | 18 +
 rtl/addsub_arbiter_addsub.sv | 29 ++
 rtl/addsub_arbiter.sv | 143 ++++++++++++++
 tb/tb_addsub_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared constants for the two-requester add/subtract arbiter.
//   ST_IDLE / ST_EXEC / ST_RESP : controller state encoding
//   ID_REQ0 / ID_REQ1           : requester identifiers carried in resp_id
package addsub_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  // Round-robin tie-break: the winner is whoever was not served last.
  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/addsub_arbiter_addsub.sv
// Shared n-bit adder/subtractor datapath.
//   x, y      : operands
//   add_n     : 0 = x+y, 1 = x-y (computed as x + ~y + 1)
//   s         : result mod 2^n
//   c_out     : carry out of the MSB (subtract: 1 = no borrow)
//   overflow  : two's-complement signed overflow
module adder_subtractor_with_overflow #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out,
  output logic         overflow
);

  logic [n-1:0] y_eff;
  logic [n:0]   sum;

  assign y_eff = add_n ? ~y : y;
  assign sum   = {1'b0, x} + {1'b0, y_eff} + {{n{1'b0}}, add_n};
  assign s     = sum[n-1:0];
  assign c_out = sum[n];

  // Signed overflow: both addends share a sign and the result sign differs.
  assign overflow = (x[n-1] == y_eff[n-1]) && (s[n-1] != x[n-1]);

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one adder/subtractor between two requesters.
//   req0_* / req1_*  : valid/ready request channels with operands and op select
//   resp_*           : tagged result channel (valid/ready)
//   ovf_sticky       : per-requester sticky overflow, bit i = requester i
//   ovf_clr          : synchronous clear of ovf_sticky bits (a same-cycle set wins)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate, accept one request, latch its operands
// EXEC  | shared datapath evaluates the latched operands, result captured
// RESP  | result presented until the consumer takes it
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_x,
  input  logic [n-1:0] req0_y,
  input  logic         req0_add_n,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_x,
  input  logic [n-1:0] req1_y,
  input  logic         req1_add_n,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [n-1:0] resp_s,
  output logic         resp_c_out,
  output logic         resp_overflow,
  output logic [1:0]   ovf_sticky,
  input  logic [1:0]   ovf_clr
);

  logic [1:0]   state;
  logic         last_grant;
  logic [n-1:0] op_x;
  logic [n-1:0] op_y;
  logic         op_add_n;
  logic         op_id;

  logic         grant_valid;
  logic         grant_id;
  logic [n-1:0] alu_s;
  logic         alu_c_out;
  logic         alu_overflow;
  logic [1:0]   ovf_set;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ID_REQ0;
    if (state == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = other_id(last_grant);
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = ID_REQ0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ID_REQ1;
      end
    end
  end

  assign req0_ready = grant_valid && (grant_id == ID_REQ0);
  assign req1_ready = grant_valid && (grant_id == ID_REQ1);

  // Datapath sees only the registered operands, never the live request buses.
  adder_subtractor_with_overflow #(.n(n)) u_addsub (
    .x        (op_x),
    .y        (op_y),
    .add_n    (op_add_n),
    .s        (alu_s),
    .c_out    (alu_c_out),
    .overflow (alu_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last_grant    <= ID_REQ1;
      op_x          <= '0;
      op_y          <= '0;
      op_add_n      <= 1'b0;
      op_id         <= ID_REQ0;
      resp_valid    <= 1'b0;
      resp_id       <= 1'b0;
      resp_s        <= '0;
      resp_c_out    <= 1'b0;
      resp_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            op_x       <= (grant_id == ID_REQ1) ? req1_x     : req0_x;
            op_y       <= (grant_id == ID_REQ1) ? req1_y     : req0_y;
            op_add_n   <= (grant_id == ID_REQ1) ? req1_add_n : req0_add_n;
            op_id      <= grant_id;
            last_grant <= grant_id;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_s        <= alu_s;
          resp_c_out    <= alu_c_out;
          resp_overflow <= alu_overflow;
          resp_id       <= op_id;
          resp_valid    <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ovf_set = 2'b00;
    if (state == ST_EXEC && alu_overflow) begin
      ovf_set[op_id] = 1'b1;
    end
  end

  // Set is OR'ed after the clear mask so a coincident set survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 2'b00;
    end else begin
      ovf_sticky <= (ovf_sticky & ~ovf_clr) | ovf_set;
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_add_n;
  logic [N-1:0] req0_x, req0_y;
  logic         req1_valid, req1_ready, req1_add_n;
  logic [N-1:0] req1_x, req1_y;
  logic         resp_valid, resp_ready, resp_id, resp_c_out, resp_overflow;
  logic [N-1:0] resp_s;
  logic [1:0]   ovf_sticky, ovf_clr;

  int vectors;
  int fails;
  logic [1:0] exp_sticky;

  addsub_arbiter #(.n(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_x        (req0_x),
    .req0_y        (req0_y),
    .req0_add_n    (req0_add_n),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_x        (req1_x),
    .req1_y        (req1_y),
    .req1_add_n    (req1_add_n),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_s        (resp_s),
    .resp_c_out    (resp_c_out),
    .resp_overflow (resp_overflow),
    .ovf_sticky    (ovf_sticky),
    .ovf_clr       (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arithmetic from plain integer math on unsigned and signed views.
  function automatic void ref_op(input logic [N-1:0] x, input logic [N-1:0] y, input bit sub,
                                 output logic [N-1:0] s, output bit c, output bit o);
    int ux, uy, sx, sy, r, m;
    m  = 1 << N;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    if (sub) begin
      s = N'((ux - uy + m) % m);
      c = (ux >= uy);
      r = sx - sy;
    end else begin
      s = N'((ux + uy) % m);
      c = (ux + uy) >= m;
      r = sx + sy;
    end
    o = (r > m / 2 - 1) || (r < -(m / 2));
  endfunction

  task automatic drive_req(input bit id, input bit v, input logic [N-1:0] x,
                           input logic [N-1:0] y, input bit a);
    if (id == 1'b0) begin
      req0_valid = v; req0_x = x; req0_y = y; req0_add_n = a;
    end else begin
      req1_valid = v; req1_x = x; req1_y = y; req1_add_n = a;
    end
  endtask

  task automatic check_resp(input string tag, input bit id, input logic [N-1:0] es,
                            input bit ec, input bit eo);
    vectors++;
    if ({resp_valid, resp_id, resp_s, resp_c_out, resp_overflow} !== {1'b1, id, es, ec, eo}) begin
      fails++;
      $display("FAIL %s resp: got v=%0b id=%0b s=%0d c=%0b o=%0b, want v=1 id=%0b s=%0d c=%0b o=%0b",
               tag, resp_valid, resp_id, resp_s, resp_c_out, resp_overflow, id, es, ec, eo);
    end
    vectors++;
    if (ovf_sticky !== exp_sticky) begin
      fails++;
      $display("FAIL %s sticky: got %b want %b", tag, ovf_sticky, exp_sticky);
    end
  endtask

  // Called at a negedge with the other requester idle.
  task automatic send_op(input string tag, input bit id, input logic [N-1:0] x,
                         input logic [N-1:0] y, input bit sub, input int hold,
                         input logic [1:0] clr_in_exec);
    logic [N-1:0] es;
    bit ec, eo, got;
    ref_op(x, y, sub, es, ec, eo);
    drive_req(id, 1'b1, x, y, sub);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!got) begin
      fails++;
      $display("FAIL %s grant: ready never seen for requester %0d", tag, id);
      drive_req(id, 1'b0, x, y, sub);
      return;
    end
    @(posedge clk); #1;
    drive_req(id, 1'b0, x, y, sub);
    ovf_clr = clr_in_exec;
    @(negedge clk);
    vectors++;
    if ({resp_valid, req1_ready, req0_ready} !== 3'b000) begin
      fails++;
      $display("FAIL %s exec: got valid=%0b ready=%b%b want 0 00", tag, resp_valid, req1_ready, req0_ready);
    end
    @(posedge clk); #1;
    ovf_clr = 2'b00;
    exp_sticky = exp_sticky & ~clr_in_exec;
    if (eo) exp_sticky[id] = 1'b1;
    @(negedge clk);
    check_resp(tag, id, es, ec, eo);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_resp({tag, "_hold"}, id, es, ec, eo);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s consume: resp_valid got %0b want 0", tag, resp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; resp_ready = 1'b0; ovf_clr = 2'b00;
    drive_req(0, 0, '0, '0, 0);
    drive_req(1, 0, '0, '0, 0);
    exp_sticky = 2'b00;
    #23;
    vectors++;
    if ({resp_valid, resp_id, resp_s, resp_c_out, resp_overflow, ovf_sticky, req0_ready, req1_ready} !== '0) begin
      fails++;
      $display("FAIL reset: outputs got v=%0b id=%0b s=%0d c=%0b o=%0b st=%b rdy=%b%b want all 0",
               resp_valid, resp_id, resp_s, resp_c_out, resp_overflow, ovf_sticky, req1_ready, req0_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    send_op("add_5_6", 0, 4'd5, 4'd6, 0, 0, 2'b00);
    vectors++;
    if (ovf_sticky !== 2'b01) begin
      fails++;
      $display("FAIL add sticky: got %b want 01", ovf_sticky);
    end
  endtask

  task automatic test_sub_cases();
    send_op("sub_7_2", 1, 4'h7, 4'h2, 1, 0, 2'b00);
    send_op("sub_3_5", 1, 4'h3, 4'h5, 1, 0, 2'b00);
    send_op("sub_8_1", 1, 4'h8, 4'h1, 1, 0, 2'b00);
    vectors++;
    if (ovf_sticky !== 2'b11) begin
      fails++;
      $display("FAIL sub sticky: got %b want 11", ovf_sticky);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] es0, es1;
    bit ec0, eo0, ec1, eo1;
    ref_op(4'd2, 4'd3, 0, es0, ec0, eo0);
    ref_op(4'd4, 4'd9, 1, es1, ec1, eo1);
    drive_req(0, 1, 4'd2, 4'd3, 0);
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp grant0: req0_ready got %0b want 1", req0_ready);
    end
    @(posedge clk); #1;
    drive_req(0, 0, 4'd2, 4'd3, 0);
    drive_req(1, 1, 4'd4, 4'd9, 1);
    @(negedge clk);
    @(posedge clk); #1;
    if (eo0) exp_sticky[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_resp("bp_hold", 0, es0, ec0, eo0);
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        fails++;
        $display("FAIL bp ready: got %b%b want 00 during RESP", req1_ready, req0_ready);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    vectors++;
    if ({resp_valid, req1_ready, req0_ready} !== 3'b010) begin
      fails++;
      $display("FAIL bp next grant: got valid=%0b ready=%b%b want 0 10", resp_valid, req1_ready, req0_ready);
    end
    @(posedge clk); #1;
    drive_req(1, 0, 4'd4, 4'd9, 1);
    @(negedge clk);
    @(posedge clk); #1;
    if (eo1) exp_sticky[1] = 1'b1;
    @(negedge clk);
    check_resp("bp_req1", 1, es1, ec1, eo1);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sticky_race();
    ovf_clr = 2'b11;
    @(posedge clk); #1;
    ovf_clr = 2'b00;
    exp_sticky = 2'b00;
    @(negedge clk);
    vectors++;
    if (ovf_sticky !== 2'b00) begin
      fails++;
      $display("FAIL race preclear: got %b want 00", ovf_sticky);
    end
    send_op("race", 0, 4'd5, 4'd6, 0, 0, 2'b01);
    vectors++;
    if (ovf_sticky[0] !== 1'b1) begin
      fails++;
      $display("FAIL race set_wins: bit0 got %0b want 1", ovf_sticky[0]);
    end
    ovf_clr = 2'b01;
    @(posedge clk); #1;
    ovf_clr = 2'b00;
    exp_sticky[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (ovf_sticky[0] !== 1'b0) begin
      fails++;
      $display("FAIL race lone_clear: bit0 got %0b want 0", ovf_sticky[0]);
    end
  endtask

  task automatic test_random();
    bit id, sub;
    logic [N-1:0] x, y;
    logic [1:0] clr;
    int hold;
    for (int i = 0; i < 24; i++) begin
      id   = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
      x    = N'($urandom_range(0, 15));
      y    = N'($urandom_range(0, 15));
      hold = $urandom_range(0, 2);
      clr  = 2'($urandom_range(0, 3));
      send_op("random", id, x, y, sub, hold, clr);
    end
  endtask

  task automatic test_reset_mid_exec();
    send_op("pre_rst", 0, 4'd7, 4'd7, 0, 0, 2'b00);
    drive_req(1, 1, 4'd7, 4'd1, 0);
    #1;
    vectors++;
    if (req1_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_exec grant: req1_ready got %0b want 1", req1_ready);
    end
    @(posedge clk); #1;
    drive_req(1, 0, 4'd7, 4'd1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    exp_sticky = 2'b00;
    vectors++;
    if ({resp_valid, resp_id, resp_s, resp_c_out, resp_overflow, ovf_sticky, req0_ready, req1_ready} !== '0) begin
      fails++;
      $display("FAIL rst_exec async: got v=%0b id=%0b s=%0d c=%0b o=%0b st=%b rdy=%b%b want all 0",
               resp_valid, resp_id, resp_s, resp_c_out, resp_overflow, ovf_sticky, req1_ready, req0_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({resp_valid, ovf_sticky} !== 3'b000) begin
        fails++;
        $display("FAIL rst_exec after: got valid=%0b sticky=%b want 0 00", resp_valid, ovf_sticky);
      end
    end
    send_op("post_rst", 1, 4'd1, 4'd2, 0, 0, 2'b00);
  endtask

  task automatic test_contention();
    logic [N-1:0] px [2];
    logic [N-1:0] py [2];
    bit pa [2];
    logic [N-1:0] es;
    bit ec, eo, g;
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      px[r] = N'($urandom_range(0, 15));
      py[r] = N'($urandom_range(0, 15));
      pa[r] = 1'($urandom_range(0, 1));
      drive_req(1'(r), 1, px[r], py[r], pa[r]);
    end
    exp_sticky = 2'b00;
    resp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      g = 1'(i % 2);
      vectors++;
      if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL contention grant %0d: ready got %b%b want %s", i, req1_ready, req0_ready, g ? "10" : "01");
      end
      ref_op(px[g], py[g], pa[g], es, ec, eo);
      @(posedge clk); #1;
      px[g] = N'($urandom_range(0, 15));
      py[g] = N'($urandom_range(0, 15));
      pa[g] = 1'($urandom_range(0, 1));
      drive_req(g, 1, px[g], py[g], pa[g]);
      @(negedge clk);
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        fails++;
        $display("FAIL contention exec ready: got %b%b want 00", req1_ready, req0_ready);
      end
      @(posedge clk); #1;
      if (eo) exp_sticky[g] = 1'b1;
      @(negedge clk);
      check_resp("contention", g, es, ec, eo);
      @(posedge clk); #1;
    end
    drive_req(0, 0, '0, '0, 0);
    drive_req(1, 0, '0, '0, 0);
    resp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    fails   = 0;
    test_reset();
    test_single_add();
    test_sub_cases();
    test_backpressure();
    test_sticky_race();
    test_random();
    test_reset_mid_exec();
    test_contention();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
